// File: rtl/char_rx_pkg.sv
// -----------------------------------------------------------------------------
// char_rx_pkg
//   Shared types for the serial character receiver.
//   rx_state_t : receiver FSM states (IDLE, START, DATA, STOP, BRK).
// -----------------------------------------------------------------------------
package char_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } rx_state_t;

endpackage : char_rx_pkg

// File: rtl/char_rx_sync.sv
// -----------------------------------------------------------------------------
// rx_sync
//   Two-flop synchronizer for an asynchronous single-bit input. Both flops
//   reset to 1 so an idle-high serial line never shows a false low edge
//   when reset is released.
//   Ports:
//     clk  - system clock
//     clr  - asynchronous active-high reset
//     i_d  - asynchronous input
//     o_q  - synchronized output
// -----------------------------------------------------------------------------
module rx_sync (
  input  logic clk,
  input  logic clr,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make r_q take the old r_meta, which
      // is exactly the two-stage pipeline; blocking would collapse it to one.
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule : rx_sync

// File: rtl/char_rx.sv
// -----------------------------------------------------------------------------
// char_rx
//   8N1 serial character receiver. Deserializes rxd (start bit, 8 data bits
//   LSB first, stop bit) into bytes for the downstream string recognizer.
//   Ports:
//     clk   - system clock, rising edge
//     clr   - asynchronous active-high reset
//     rxd   - raw serial line, idle high, asynchronous to clk
//     data  - last correctly framed character, held between frames
//     valid - one-cycle pulse, data updated this cycle
//     ferr  - one-cycle pulse, stop bit sampled low
//     busy  - high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module char_rx
  import char_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  // Compare points: start bit is sampled mid-bit, data/stop one bit later.
  localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] C_FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            w_rs;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bi;
  logic [7:0]      r_sh;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_ferr;
  logic            r_busy;

  rx_sync u_sync (
    .clk (clk),
    .clr (clr),
    .i_d (rxd),
    .o_q (w_rs)
  );

  // Single registered FSM; r_busy is assigned alongside every state change
  // so it always reflects the state being entered.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bi    <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rs) begin
            r_state <= ST_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end

        ST_START: begin
          r_busy <= 1'b1;
          if (r_cnt == C_HALF_M1) begin
            if (!w_rs) begin
              r_state <= ST_DATA;
              r_cnt   <= '0;
              r_bi    <= '0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          r_busy <= 1'b1;
          if (r_cnt == C_FULL_M1) begin
            // LSB arrives first, so shifting in at the MSB leaves bit 0 last.
            r_sh  <= {w_rs, r_sh[7:1]};
            r_cnt <= '0;
            if (r_bi == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bi <= r_bi + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (r_cnt == C_FULL_M1) begin
            if (w_rs) begin
              r_data  <= r_sh;
              r_valid <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= ST_BRK;
              r_busy  <= 1'b1;
            end
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_busy <= 1'b1;
          end
        end

        ST_BRK: begin
          // Hold off until the line idles so a break is not seen as a start.
          if (w_rs) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_busy  <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign ferr  = r_ferr;
  assign busy  = r_busy;

endmodule : char_rx

// File: tb/tb_char_rx.sv
// -----------------------------------------------------------------------------
// tb_char_rx
//   Self-checking bench for char_rx with CLKS_PER_BIT = 4. Each frame pushes
//   its expected outcome (good byte or framing error, data, arrival cycle)
//   into a scoreboard queue; a negedge monitor pops and compares on every
//   valid/ferr pulse.
// -----------------------------------------------------------------------------
module tb_char_rx;

  localparam int N   = 4;
  localparam int H   = N / 2;
  localparam int LAT = 2 + H + 9 * N;  // first low-sampling edge to valid

  typedef struct {
    bit         err;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       clr;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       busy;

  int         n_total;
  int         n_bad;
  int         cyc;
  logic [7:0] model_data;
  exp_t       sb[$];

  char_rx #(.CLKS_PER_BIT(N)) dut (
    .clk   (clk),
    .clr   (clr),
    .rxd   (rxd),
    .data  (data),
    .valid (valid),
    .ferr  (ferr),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one 8N1 frame starting at a negedge; rxd stays at the stop level.
  task automatic send_frame(input logic [7:0] d, input bit stop);
    exp_t       e;
    logic [9:0] bits;
    e.err = !stop;
    e.d   = stop ? d : model_data;
    e.cyc = cyc + 1 + LAT;
    sb.push_back(e);
    if (stop) model_data = d;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (N) @(negedge clk);
    end
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!clr && (valid || ferr)) begin
      check("valid_ferr_exclusive", {31'd0, valid & ferr}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, valid, ferr}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind_ferr", {31'd0, ferr}, {31'd0, e.err});
        check("pulse_data", {24'd0, data}, {24'd0, e.d});
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    n_total    = 0;
    n_bad      = 0;
    model_data = 8'h00;
    clr        = 1'b1;
    rxd        = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {21'd0, data, valid, ferr, busy}, 32'd0);
    clr = 1'b0;

    // Idle line: everything stays quiet
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outputs", {21'd0, data, valid, ferr, busy}, 32'd0);
    end

    // Single good frame '5'
    send_frame(8'h35, 1'b1);
    repeat (8) @(negedge clk);

    // Back-to-back "1a2" with no idle gap
    send_frame(8'h31, 1'b1);
    send_frame(8'h61, 1'b1);
    send_frame(8'h32, 1'b1);
    repeat (8) @(negedge clk);
    check("data_after_b2b", {24'd0, data}, 32'h32);

    // One-clock glitch: rejected, busy drops H+2 clocks after the fall
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    repeat (8) @(negedge clk);

    // Framing error followed by a held break
    send_frame(8'h41, 1'b0);
    repeat (20) @(negedge clk);
    check("brk_busy_held", {31'd0, busy}, 32'd1);
    check("brk_data_held", {24'd0, data}, {24'd0, model_data});
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    check("brk_busy_until_rise", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("brk_busy_released", {31'd0, busy}, 32'd0);
    repeat (8) @(negedge clk);

    // clr in the middle of bit 4 of an 8'h39 frame (partial frame not queued)
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'h39, 1'b0};
      for (int i = 0; i < 5; i++) begin
        rxd = bits[i];
        repeat (N) @(negedge clk);
      end
      rxd = bits[5];
      repeat (2) @(negedge clk);
    end
    clr = 1'b1;
    rxd = 1'b1;
    model_data = 8'h00;
    @(negedge clk);
    check("clr_outputs_0", {21'd0, data, valid, ferr, busy}, 32'd0);
    @(negedge clk);
    check("clr_outputs_1", {21'd0, data, valid, ferr, busy}, 32'd0);
    clr = 1'b0;
    repeat (2 * N) @(negedge clk);
    check("post_clr_idle", {21'd0, data, valid, ferr, busy}, 32'd0);
    send_frame(8'h37, 1'b1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    repeat (4) @(negedge clk);
    check("final_data", {24'd0, data}, 32'h37);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard stop if the sequence above never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_char_rx
